// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'b00,
      ARB_REQ  = 2'b01,
      ARB_WAIT = 2'b10
   } arb_state_e;

   typedef enum logic {
      OWNER_IF = 1'b0,
      OWNER_DM = 1'b1
   } owner_e;

   localparam logic [2:0] RW_TYPE_WORD = 3'b010;
   localparam int         TIMER_W      = 16;
   localparam int         STREAK_W     = 8;

   function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] val,
                                                   input logic [STREAK_W-1:0] lim);
      if (val >= lim) begin
         sat_inc = lim;
      end else begin
         sat_inc = val + {{(STREAK_W-1){1'b0}}, 1'b1};
      end
   endfunction

endpackage

// File: rtl/mem_port_arbiter_timer.sv
// Busy-cycle counter for the arbiter; flags the cycle on which a stuck access
// must be abandoned. TIMEOUT_CYCLES of 0 disables the flag.
module mem_port_arbiter_timer
   import mem_port_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic clr_i,
   output logic expired_o
);

   logic [TIMER_W-1:0] cnt_q;
   logic [TIMER_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {TIMER_W{1'b0}};
      end else if (en_i) begin
         cnt_d = cnt_q + {{(TIMER_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= {TIMER_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Count starts at 0 in the first busy cycle, so the limit is reached at TIMEOUT_CYCLES-1.
   generate
      if (TIMEOUT_CYCLES == 0) begin : g_off
         assign expired_o = 1'b0;
      end else begin : g_on
         assign expired_o = en_i && (cnt_q == TIMER_W'(TIMEOUT_CYCLES - 1));
      end
   endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported, variable-latency memory between instruction fetch
// and the data stage, with starvation protection and a response timeout.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_DM_STREAK  = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   input  logic        flush_if_i,
   output logic [31:0] if_rdata_o,
   output logic        if_valid_o,
   input  logic        dm_req_i,
   input  logic        dm_we_i,
   input  logic [2:0]  dm_rw_type_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_wdata_i,
   output logic [31:0] dm_rdata_o,
   output logic        dm_valid_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [2:0]  mem_rw_type_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        stall_if_o,
   output logic        stall_mem_o,
   output logic        bus_err_o
);

   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

   arb_state_e          state_q, state_d;
   owner_e              owner_q, owner_d;
   logic                drop_q, drop_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic                mem_req_q, mem_req_d;
   logic                we_q, we_d;
   logic [2:0]          rw_type_q, rw_type_d;
   logic [31:0]         addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                bus_err_q, bus_err_d;

   logic                rsp_done;
   logic                rsp_err;
   logic                rsp_fire;
   logic [31:0]         rsp_data;
   logic                timer_expired;

   mem_port_arbiter_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .en_i      (state_q != ARB_IDLE),
      .clr_i     (state_q == ARB_IDLE),
      .expired_o (timer_expired)
   );

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      drop_d    = drop_q;
      streak_d  = streak_q;
      mem_req_d = mem_req_q;
      we_d      = we_q;
      rw_type_d = rw_type_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rsp_done  = 1'b0;
      rsp_err   = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            drop_d = 1'b0;
            // Data wins unless fetch has been passed over MAX_DM_STREAK times in a row.
            if (dm_req_i && !(if_req_i && (streak_q == STREAK_MAX))) begin
               owner_d   = OWNER_DM;
               we_d      = dm_we_i;
               rw_type_d = dm_rw_type_i;
               addr_d    = dm_addr_i;
               wdata_d   = dm_wdata_i;
               streak_d  = if_req_i ? sat_inc(streak_q, STREAK_MAX) : {STREAK_W{1'b0}};
               mem_req_d = 1'b1;
               state_d   = ARB_REQ;
            end else if (if_req_i) begin
               owner_d   = OWNER_IF;
               we_d      = 1'b0;
               rw_type_d = RW_TYPE_WORD;
               addr_d    = if_addr_i;
               wdata_d   = 32'h0000_0000;
               streak_d  = {STREAK_W{1'b0}};
               mem_req_d = 1'b1;
               state_d   = ARB_REQ;
            end else begin
               streak_d  = {STREAK_W{1'b0}};
            end
         end
         ARB_REQ: begin
            drop_d = drop_q | (flush_if_i && (owner_q == OWNER_IF));
            if (timer_expired) begin
               rsp_err   = 1'b1;
               mem_req_d = 1'b0;
               state_d   = ARB_IDLE;
            end else if (mem_gnt_i) begin
               mem_req_d = 1'b0;
               state_d   = ARB_WAIT;
            end else begin
               state_d   = ARB_REQ;
            end
         end
         ARB_WAIT: begin
            drop_d = drop_q | (flush_if_i && (owner_q == OWNER_IF));
            // A real response arriving on the timeout cycle takes precedence over the abort.
            if (mem_rvalid_i) begin
               rsp_done = 1'b1;
               state_d  = ARB_IDLE;
            end else if (timer_expired) begin
               rsp_err  = 1'b1;
               state_d  = ARB_IDLE;
            end else begin
               state_d  = ARB_WAIT;
            end
         end
         default: begin
            mem_req_d = 1'b0;
            state_d   = ARB_IDLE;
         end
      endcase
      bus_err_d = bus_err_q | rsp_err;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ARB_IDLE;
         owner_q   <= OWNER_IF;
         drop_q    <= 1'b0;
         streak_q  <= {STREAK_W{1'b0}};
         mem_req_q <= 1'b0;
         we_q      <= 1'b0;
         rw_type_q <= 3'b000;
         addr_q    <= 32'h0000_0000;
         wdata_q   <= 32'h0000_0000;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         drop_q    <= drop_d;
         streak_q  <= streak_d;
         mem_req_q <= mem_req_d;
         we_q      <= we_d;
         rw_type_q <= rw_type_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign rsp_fire = rsp_done | rsp_err;
   assign rsp_data = rsp_done ? mem_rdata_i : 32'h0000_0000;

   // Same-cycle flush also suppresses the fetch response, not only the registered drop.
   assign if_valid_o  = rsp_fire && (owner_q == OWNER_IF) && !drop_q && !flush_if_i;
   assign dm_valid_o  = rsp_fire && (owner_q == OWNER_DM);
   assign if_rdata_o  = if_valid_o ? rsp_data : 32'h0000_0000;
   assign dm_rdata_o  = dm_valid_o ? rsp_data : 32'h0000_0000;

   assign stall_if_o  = if_req_i & ~if_valid_o;
   assign stall_mem_o = dm_req_i & ~dm_valid_o;

   assign mem_req_o     = mem_req_q;
   assign mem_we_o      = we_q;
   assign mem_rw_type_o = rw_type_q;
   assign mem_addr_o    = addr_q;
   assign mem_wdata_o   = wdata_q;
   assign bus_err_o     = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected responses are queued as requests
// are issued and matched against every valid the arbiter produces.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_i, flush_if_i, if_valid_o;
   logic [31:0] if_addr_i, if_rdata_o;
   logic        dm_req_i, dm_we_i, dm_valid_o;
   logic [2:0]  dm_rw_type_i;
   logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
   logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
   logic [2:0]  mem_rw_type_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic        stall_if_o, stall_mem_o, bus_err_o;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .MAX_DM_STREAK (4),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .if_req_i     (if_req_i),
      .if_addr_i    (if_addr_i),
      .flush_if_i   (flush_if_i),
      .if_rdata_o   (if_rdata_o),
      .if_valid_o   (if_valid_o),
      .dm_req_i     (dm_req_i),
      .dm_we_i      (dm_we_i),
      .dm_rw_type_i (dm_rw_type_i),
      .dm_addr_i    (dm_addr_i),
      .dm_wdata_i   (dm_wdata_i),
      .dm_rdata_o   (dm_rdata_o),
      .dm_valid_o   (dm_valid_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_rw_type_o(mem_rw_type_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .stall_if_o   (stall_if_o),
      .stall_mem_o  (stall_mem_o),
      .bus_err_o    (bus_err_o)
   );

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [32:0] sb[$];          // {is_dm, rdata}
   logic [32:0] mon_exp;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for the request, grants it, leaves one idle WAIT cycle, then returns data.
   task automatic serve(input logic [31:0] data, output int lat, output logic [31:0] addr,
                        output logic we, output logic [2:0] rw, output logic [31:0] wdata);
      lat = 0;
      while (mem_req_o !== 1'b1 && lat < 12) begin
         tick();
         lat++;
      end
      chk("req_seen", mem_req_o, 1'b1);
      addr  = mem_addr_o;
      we    = mem_we_o;
      rw    = mem_rw_type_o;
      wdata = mem_wdata_o;
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0;
      chk("req_dropped_after_gnt", mem_req_o, 1'b0);
      tick();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = data;
      tick();
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0;
   endtask

   always @(negedge clk) begin
      if (!rst && (if_valid_o || dm_valid_o)) begin
         chk("valid_exclusive", {63'h0, if_valid_o & dm_valid_o}, 64'h0);
         if (sb.size() == 0) begin
            chk("unexpected_valid", {62'h0, dm_valid_o, if_valid_o}, 64'h0);
         end else begin
            mon_exp = sb.pop_front();
            chk("rsp_owner_data", {31'h0, dm_valid_o, dm_valid_o ? dm_rdata_o : if_rdata_o},
                {31'h0, mon_exp});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      int          lat;
      logic [31:0] a, wd;
      logic        w;
      logic [2:0]  rw;
      logic        exp_dm[7];

      rst = 1'b1; if_req_i = 1'b0; if_addr_i = 32'h0; flush_if_i = 1'b0;
      dm_req_i = 1'b0; dm_we_i = 1'b0; dm_rw_type_i = 3'b000; dm_addr_i = 32'h0;
      dm_wdata_i = 32'h0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
      tick();
      tick();
      chk("rst_mem_req", mem_req_o, 1'b0);
      chk("rst_mem_addr", mem_addr_o, 32'h0);
      chk("rst_valids", {if_valid_o, dm_valid_o}, 2'b00);
      chk("rst_bus_err", bus_err_o, 1'b0);
      rst = 1'b0;
      tick();

      // 1: single fetch, latency N+1 to mem_req_o
      if_req_i = 1'b1; if_addr_i = 32'h100;
      sb.push_back({1'b0, 32'h0050_0093});
      #1 chk("t1_stall_if_pending", stall_if_o, 1'b1);
      serve(32'h0050_0093, lat, a, w, rw, wd);
      chk("t1_latency", lat, 1);
      chk("t1_addr", a, 32'h100);
      chk("t1_fields", {w, rw}, {1'b0, 3'b010});
      if_req_i = 1'b0;
      #1 chk("t1_stall_if_clear", stall_if_o, 1'b0);
      tick();

      // 2: simultaneous IF and DM store; data first with its fields passed through
      if_req_i = 1'b1; if_addr_i = 32'h300;
      dm_req_i = 1'b1; dm_we_i = 1'b1; dm_rw_type_i = 3'b001;
      dm_addr_i = 32'h2000; dm_wdata_i = 32'hDEAD_BEEF;
      sb.push_back({1'b1, 32'h0});
      sb.push_back({1'b0, 32'h0000_0013});
      #1 chk("t2_stalls", {stall_if_o, stall_mem_o}, 2'b11);
      serve(32'h0, lat, a, w, rw, wd);
      chk("t2_dm_addr", a, 32'h2000);
      chk("t2_dm_fields", {w, rw}, {1'b1, 3'b001});
      chk("t2_dm_wdata", wd, 32'hDEAD_BEEF);
      dm_req_i = 1'b0; dm_we_i = 1'b0;
      serve(32'h0000_0013, lat, a, w, rw, wd);
      chk("t2_if_addr", a, 32'h300);
      chk("t2_if_fields", {w, rw}, {1'b0, 3'b010});
      if_req_i = 1'b0;
      tick();

      // 3: DM held continuously with IF pending; fetch forced in as the 5th grant
      exp_dm = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      dm_req_i = 1'b1; dm_rw_type_i = 3'b010; dm_addr_i = 32'h4000;
      if_req_i = 1'b1; if_addr_i = 32'h500;
      for (int k = 0; k < 7; k++) begin
         sb.push_back({exp_dm[k], 32'hA000_0000 + 32'(k)});
         serve(32'hA000_0000 + 32'(k), lat, a, w, rw, wd);
         chk($sformatf("t3_grant%0d_addr", k), a, exp_dm[k] ? 32'h4000 : 32'h500);
         if (k == 4) if_req_i = 1'b0;
      end
      dm_req_i = 1'b0;
      tick();

      // 4: flush while fetch is in WAIT; response swallowed, redirected fetch served
      if_req_i = 1'b1; if_addr_i = 32'h180;
      tick();
      chk("t4_req", mem_req_o, 1'b1);
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0; flush_if_i = 1'b1;
      tick();
      flush_if_i = 1'b0; if_addr_i = 32'h200;
      tick();
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0BAD_0BAD;
      #1 chk("t4_if_valid_dropped", if_valid_o, 1'b0);
      chk("t4_stall_if_held", stall_if_o, 1'b1);
      tick();
      mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
      chk("t4_idle_no_req", mem_req_o, 1'b0);
      sb.push_back({1'b0, 32'h0000_0297});
      serve(32'h0000_0297, lat, a, w, rw, wd);
      chk("t4_new_fetch_addr", a, 32'h200);
      if_req_i = 1'b0;
      tick();

      // 5: granted load never answered; abort on the 8th busy cycle
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_rw_type_i = 3'b010; dm_addr_i = 32'h6000;
      mem_rdata_i = 32'hFFFF_FFFF;
      sb.push_back({1'b1, 32'h0});
      tick();
      chk("t5_req", mem_req_o, 1'b1);
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0;
      for (int c = 2; c < 8; c++) begin
         #1 chk($sformatf("t5_no_valid_c%0d", c), dm_valid_o, 1'b0);
         tick();
      end
      #1 chk("t5_timeout_valid", dm_valid_o, 1'b1);
      chk("t5_timeout_rdata", dm_rdata_o, 32'h0);
      tick();
      dm_req_i = 1'b0;
      chk("t5_bus_err_set", bus_err_o, 1'b1);
      chk("t5_idle", mem_req_o, 1'b0);
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234;
      #1 chk("t5_late_rvalid_ignored", {if_valid_o, dm_valid_o}, 2'b00);
      tick();
      mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
      tick();
      chk("t5_bus_err_sticky", bus_err_o, 1'b1);

      // 6: reset during WAIT with a response arriving; nothing is delivered
      if_req_i = 1'b1; if_addr_i = 32'h700;
      tick();
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0;
      tick();
      rst = 1'b1; if_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55;
      #1 chk("t6_rst_valid", if_valid_o, 1'b0);
      chk("t6_rst_rdata", if_rdata_o, 32'h0);
      chk("t6_rst_bus_err", bus_err_o, 1'b0);
      chk("t6_rst_mem_addr", mem_addr_o, 32'h0);
      tick();
      rst = 1'b0;
      #1 chk("t6_inflight_ignored", {if_valid_o, dm_valid_o}, 2'b00);
      tick();
      mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
      if_req_i = 1'b1; if_addr_i = 32'h800;
      sb.push_back({1'b0, 32'h1111_1111});
      serve(32'h1111_1111, lat, a, w, rw, wd);
      chk("t6_post_rst_addr", a, 32'h800);
      if_req_i = 1'b0;
      tick();
      tick();

      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
